operand_entry: RTL

Upstream input stage for the tiny calculator.
- Two 4-bit operands entered sequentially on SW[3:0], each confirmed with a push-button.
- Registered OP_A/OP_B feed the combinational 4-bit adder and display decoders.
- Adds button synchronisation, debouncing, edge detection and an entry state machine, so one switch bank serves both operands.

---
 rtl/operand_entry.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/operand_entry.sv
// operand_entry: front end of the tiny calculator.
// Two 4-bit operands are typed on SW and confirmed with KEY[0] (enter);
// KEY[1] (clear) aborts the entry. Keys are synchronised, optionally
// debounced, edge-detected and fed to a three-state entry FSM.
// Optional feature macro: OPERAND_DEBOUNCE_EN (defined = debounce counters
// built and DEBOUNCE_CYCLES honoured; undefined = synced level used directly).
module operand_entry #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [3:0] SW,
    input  logic [1:0] KEY,
    output logic [3:0] OP_A,
    output logic [3:0] OP_B,
    output logic       OPS_VALID,
    output logic       OPS_STROBE,
    output logic [2:0] LEDG
);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_fill;
    logic [1:0] r_armed;
    logic [1:0] r_deb_prev;
    logic [1:0] w_deb;
    logic [1:0] w_press;
    logic       w_enter;
    logic       w_clear;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_op_a;
    logic [3:0] r_op_b;
    logic       r_valid;
    logic       r_strobe;
    logic [2:0] r_ledg;
    logic       w_valid_next;
    logic       w_strobe_next;
    logic [2:0] w_ledg_next;

    // Two-flop synchroniser for the asynchronous, active-low keys.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
        end else begin
            r_sync1 <= KEY;
            r_sync2 <= r_sync1;
        end
    end

    // Counts the edges needed before r_sync2 shows the real key level
    // rather than the values preloaded by reset.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_fill <= 2'd0;
        end else if (r_fill != 2'd2) begin
            r_fill <= r_fill + 2'd1;
        end
    end

`ifdef OPERAND_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] r_cnt [2];
    logic [1:0]    r_deb;

    // Per-key debounce: a new level is accepted only after it has been
    // seen for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_deb <= 2'b11;
            for (int k = 0; k < 2; k++) r_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (r_sync2[k] == r_deb[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == CW'(DEBOUNCE_CYCLES)) begin
                    r_deb[k] <= r_sync2[k];
                    r_cnt[k] <= '0;
                end else begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign w_deb = r_deb;
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign w_deb = r_sync2;
`endif

    // A key only becomes eligible to press once it has been seen released
    // after reset, so a key held through reset release is ignored.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_armed <= 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (r_fill == 2'd2 && r_sync2[k] && w_deb[k]) r_armed[k] <= 1'b1;
            end
        end
    end

    // Previous debounced level for 1->0 edge detection.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) r_deb_prev <= 2'b11;
        else       r_deb_prev <= w_deb;
    end

    assign w_press = r_armed & r_deb_prev & ~w_deb;
    assign w_enter = w_press[0];
    assign w_clear = w_press[1];

    // FSM state register.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) r_state <= S_A;
        else       r_state <= w_next;
    end

    // FSM next state: clear beats enter.
    always_comb begin
        w_next = r_state;
        if (w_clear) begin
            w_next = S_A;
        end else if (w_enter) begin
            case (r_state)
                S_A:     w_next = S_B;
                S_B:     w_next = S_DONE;
                S_DONE:  w_next = S_A;
                default: w_next = S_A;
            endcase
        end
    end

    // FSM output decode, computed from the next state so the registered
    // outputs change on the same edge as the state.
    always_comb begin
        w_ledg_next   = 3'b001;
        w_valid_next  = 1'b0;
        w_strobe_next = 1'b0;
        case (w_next)
            S_A:     w_ledg_next = 3'b001;
            S_B:     w_ledg_next = 3'b010;
            S_DONE:  w_ledg_next = 3'b100;
            default: w_ledg_next = 3'b001;
        endcase
        if (w_next == S_DONE) begin
            w_valid_next  = 1'b1;
            w_strobe_next = (r_state != S_DONE);
        end
    end

    // Registered status outputs.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_ledg   <= 3'b001;
            r_valid  <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_ledg   <= w_ledg_next;
            r_valid  <= w_valid_next;
            r_strobe <= w_strobe_next;
        end
    end

    // Operand capture: SW is sampled only on the edge that consumes enter.
    always_ff @(posedge CLOCK_50) begin
        if (RESET || w_clear) begin
            r_op_a <= 4'h0;
            r_op_b <= 4'h0;
        end else if (w_enter) begin
            if (r_state == S_A) r_op_a <= SW;
            if (r_state == S_B) r_op_b <= SW;
        end
    end

    assign OP_A       = r_op_a;
    assign OP_B       = r_op_b;
    assign OPS_VALID  = r_valid;
    assign OPS_STROBE = r_strobe;
    assign LEDG       = r_ledg;

endmodule
